btb_nway: RTL and testbench
===========================

# btb_nway

Parametrised N-way set-associative branch target buffer for the fetch front end. It holds per-slot prediction info, hashed tag and target, with explicit valid bits and tree pseudo-LRU replacement across `BTB_WAYS` ways. A sequencer invalidates the whole array one set per cycle on a flush request. It keeps the two-stage lookup (REQ→RESP) and two-stage update (update0→update1) pipelines of the current BTB, and reports a hit flag and an update way per instruction slot.

## Interface
Parameters:
- `BTB_SETS`, 512: number of sets; power of 2, ≥2; `LOG_SETS = $clog2(BTB_SETS)`.
- `BTB_WAYS`, 4: associativity; power of 2, ≥2; `LOG_WAYS = $clog2(BTB_WAYS)`.
- `BTB_ENTRIES_PER_BLOCK`, 8: instruction slots per fetch block; power of 2; `LOG_EPB = $clog2(BTB_ENTRIES_PER_BLOCK)`.
- `BTB_PRED_INFO_WIDTH`, 8: width of the prediction info field.
- `BTB_TAG_WIDTH`, 6: width of the hashed tag.
- `BTB_TARGET_WIDTH`, 10: stored target width, taken from `PC[TARGET_WIDTH:1]`.
- `ASID_WIDTH`, 9: width of the ASID.

Ports:
- `CLK` in 1: clock.
- `RST` in 1: reset. One clock; reset is synchronous and active-high.
- `valid_REQ` in 1: lookup request.
- `full_PC_REQ` in 32: fetch block PC.
- `ASID_REQ` in `ASID_WIDTH`: ASID of the lookup.
- `ready_REQ` out 1: 1 when the FSM is in IDLE.
- `valid_RESP` out 1: response valid.
- `hit_by_instr_RESP` out `EPB`: per-slot hit flag.
- `pred_info_by_instr_RESP` out `EPB×PRED_INFO_WIDTH`: pred info of the hit way, 0 on miss.
- `target_by_instr_RESP` out `EPB×TARGET_WIDTH`: target of the hit way, 0 on miss.
- `way_by_instr_RESP` out `EPB×LOG_WAYS`: hit way on a hit, PLRU victim on a miss.
- `update0_valid` in 1: update request.
- `update0_start_full_PC` in 32: PC of the instruction being updated.
- `update0_ASID` in `ASID_WIDTH`: ASID of the update.
- `update1_pred_info` in `PRED_INFO_WIDTH`: pred info to write (update1 cycle).
- `update1_way` in `LOG_WAYS`: way to write (update1 cycle).
- `update1_target_full_PC` in 32: target PC to write (update1 cycle).
- `update1_invalidate` in 1: clear the entry instead of writing it (update1 cycle).
- `flush_req` in 1: request an invalidate of the whole array.
- `flush_done` out 1: one-cycle pulse when the flush completes.

## Operation
Address fields:
- index = `PC[LOG_SETS+LOG_EPB : LOG_EPB+1]`.
- slot = `PC[LOG_EPB:1]`.
- tag = `PC[TAG_WIDTH+LOG_SETS+LOG_EPB : LOG_SETS+LOG_EPB+1] ^ ASID[TAG_WIDTH-1:0]`. If `ASID_WIDTH < TAG_WIDTH`, the ASID is zero-extended.

Storage per set, slot and way: {valid, pred_info, tag, target}. Per set and slot: `BTB_WAYS-1` PLRU bits.

Lookup:
- A request is accepted when `valid_REQ & ready_REQ`. The set is read, and per slot and way, match = valid & (tag == stored tag).
- Way 0..N-1 priority: the lowest matching way wins. Pred info and target are muxed from the winning way, else 0.

Tree PLRU:
- Node 0 is the root. The children of node k are 2k+1 and 2k+2.
- Bit value 0 points to the lower half, 1 to the upper half.
- Victim: follow the bits from the root down to a leaf.
- On a write to way w: every node on w's path is set to point away from w.
- PLRU is updated only by update1 writes. Lookups never change it.

Update:
- update0 registers index, slot, tag and valid, and reads the PLRU of the set.
- In the update1 cycle, when `update1_valid`:
  - If `update1_invalidate = 0`: write {1, pred_info, tag, target} to (index, slot, `update1_way`) and update PLRU.
  - If `update1_invalidate = 1`: clear the valid bit of that entry; PLRU is untouched.
- Forwarding: if the previous cycle's update1 was valid and hit the same index, the update1 PLRU base is that update's new PLRU, not the stale read.

Flush FSM:
- IDLE: `flush_req` moves to FLUSH with the set counter at 0.
- FLUSH: clear all valid bits and PLRU bits of set[counter], then counter+1. At counter = `BTB_SETS-1`, go to IDLE and pulse `flush_done`.
- While in FLUSH: `ready_REQ = 0`, update1 writes are dropped, and `flush_req` is ignored.

## Timing
- Lookup latency is 1 cycle: accepted at cycle t, RESP outputs valid at t+1. RESP outputs are driven only while `valid_RESP` is 1.
- A flush takes exactly `BTB_SETS` cycles in FLUSH. `flush_done` is asserted in the cycle the FSM returns to IDLE. `ready_REQ` rises in that same cycle.
- Read-before-write: an update1 write and a REQ read of the same set in the same cycle return the old contents. The new data is visible to a REQ issued in the next cycle.
- A `flush_req` in the same cycle as an update1 write: the write is performed, and the flush starts the next cycle.
- Reset values:
  - Storage: all valid bits and PLRU bits 0.
  - FSM: IDLE, counter 0.
  - Outputs: `ready_REQ = 1`; `valid_RESP`, `flush_done`, `hit_by_instr_RESP`, pred_info, target and way all 0.
  - Update pipeline: valid 0, forwarding flag 0.
- `RST` during FLUSH aborts the flush immediately. The array is already cleared by reset, and `flush_done` is not pulsed.

## Test plan
- Reset, then a lookup at PC 0x1000, ASID 0 → `valid_RESP = 1` at t+1; `hit_by_instr_RESP = 0`; all ways report victim 0.
- Update at PC 0x1004 (slot 2), way 1, pred_info 0xA5, target 0x2000, then a lookup at 0x1000 → slot 2 hit, pred_info 0xA5, target 0x000 (`0x2000[10:1]`), way 1. Other slots miss.
- `BTB_WAYS = 4`, writes to one (set, slot) on the victim each time, starting from reset → victim sequence 0, 2, 1, 3.
- Back-to-back update1s to the same set, slots 0 then 1 → the second write's PLRU keeps slot 0's change (forwarding). A lookup then reports victim 2 for slot 0 and victim 2 for slot 1.
- Same PC, different ASID (0 vs 1) after a write under ASID 0 → ASID 1 misses, ASID 0 hits.
- `flush_req` after filling entries → `ready_REQ = 0` for `BTB_SETS` cycles; `flush_done` pulses once; all subsequent lookups miss. An update issued during the flush leaves no entry behind.

Source files
------------

// File: rtl/btb_nway.sv
// btb_nway: N-way set-associative branch target buffer with tree PLRU,
// two-stage lookup/update pipelines and a one-set-per-cycle flush sequencer.
module btb_nway #(
    parameter int BTB_SETS              = 512,
    parameter int BTB_WAYS              = 4,
    parameter int BTB_ENTRIES_PER_BLOCK = 8,
    parameter int BTB_PRED_INFO_WIDTH   = 8,
    parameter int BTB_TAG_WIDTH         = 6,
    parameter int BTB_TARGET_WIDTH      = 10,
    parameter int ASID_WIDTH            = 9,
    localparam int LOG_SETS = $clog2(BTB_SETS),
    localparam int LOG_WAYS = $clog2(BTB_WAYS),
    localparam int LOG_EPB  = $clog2(BTB_ENTRIES_PER_BLOCK),
    localparam int EPB      = BTB_ENTRIES_PER_BLOCK,
    localparam int PIW      = BTB_PRED_INFO_WIDTH,
    localparam int TGW      = BTB_TARGET_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    valid_REQ,
    input  logic [31:0]             full_PC_REQ,
    input  logic [ASID_WIDTH-1:0]   ASID_REQ,
    output logic                    ready_REQ,
    output logic                    valid_RESP,
    output logic [EPB-1:0]          hit_by_instr_RESP,
    output logic [EPB*PIW-1:0]      pred_info_by_instr_RESP,
    output logic [EPB*TGW-1:0]      target_by_instr_RESP,
    output logic [EPB*LOG_WAYS-1:0] way_by_instr_RESP,
    input  logic                    update0_valid,
    input  logic [31:0]             update0_start_full_PC,
    input  logic [ASID_WIDTH-1:0]   update0_ASID,
    input  logic [PIW-1:0]          update1_pred_info,
    input  logic [LOG_WAYS-1:0]     update1_way,
    input  logic [31:0]             update1_target_full_PC,
    input  logic                    update1_invalidate,
    input  logic                    flush_req,
    output logic                    flush_done
);

    localparam int TAGW = BTB_TAG_WIDTH;
    localparam int ENTW = PIW + TAGW + TGW;
    localparam int PLW  = BTB_WAYS - 1;
    localparam int ROWW = EPB * PLW;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t              state_q;
    logic [LOG_SETS-1:0] flush_cnt_q;
    logic                flush_done_q;

    logic [EPB*BTB_WAYS-1:0] vld_q  [BTB_SETS];
    logic [ROWW-1:0]         plru_q [BTB_SETS];
    logic [ENTW-1:0]         mem_q  [BTB_SETS][EPB*BTB_WAYS];

    logic                valid_resp_q;
    logic [EPB-1:0]      hit_q;
    logic [EPB*PIW-1:0]  pi_q;
    logic [EPB*TGW-1:0]  tgt_q;
    logic [EPB*LOG_WAYS-1:0] way_q;

    logic                u1_valid_q;
    logic [LOG_SETS-1:0] u1_idx_q;
    logic [LOG_EPB-1:0]  u1_slot_q;
    logic [TAGW-1:0]     u1_tag_q;
    logic [ROWW-1:0]     u1_row_q;
    logic                fwd_q;
    logic [LOG_SETS-1:0] fwd_idx_q;
    logic [ROWW-1:0]     fwd_row_q;

    logic [ROWW-1:0]     u1_base;
    logic [ROWW-1:0]     u1_new_row;
    logic                wr_en;
    logic                req_fire;

    logic [LOG_SETS-1:0] req_idx;
    logic [TAGW-1:0]     req_tag;
    logic [LOG_SETS-1:0] u0_idx;
    logic [LOG_EPB-1:0]  u0_slot;
    logic [TAGW-1:0]     u0_tag;

    logic [EPB-1:0]          lk_hit;
    logic [EPB*PIW-1:0]      lk_pi;
    logic [EPB*TGW-1:0]      lk_tgt;
    logic [EPB*LOG_WAYS-1:0] lk_way;
    logic [ENTW-1:0]         ent;

    logic unused_in;

    function automatic logic [LOG_SETS-1:0] get_idx(input logic [31:0] pc);
        return pc[LOG_SETS+LOG_EPB:LOG_EPB+1];
    endfunction

    function automatic logic [LOG_EPB-1:0] get_slot(input logic [31:0] pc);
        return pc[LOG_EPB:1];
    endfunction

    function automatic logic [TAGW-1:0] get_tag(
        input logic [31:0]           pc,
        input logic [ASID_WIDTH-1:0] asid
    );
        logic [TAGW+ASID_WIDTH-1:0] a;
        a = {{TAGW{1'b0}}, asid};
        return pc[TAGW+LOG_SETS+LOG_EPB:LOG_SETS+LOG_EPB+1] ^ a[TAGW-1:0];
    endfunction

    function automatic logic [LOG_WAYS-1:0] plru_victim(input logic [PLW-1:0] bits);
        logic [LOG_WAYS-1:0] v;
        logic b;
        int n;
        v = '0;
        n = 0;
        for (int l = 0; l < LOG_WAYS; l++) begin
            b = bits[n];
            v[LOG_WAYS-1-l] = b;
            n = 2 * n + 1 + int'(b);
        end
        return v;
    endfunction

    function automatic logic [PLW-1:0] plru_touch(
        input logic [PLW-1:0]      bits,
        input logic [LOG_WAYS-1:0] way
    );
        logic [PLW-1:0] r;
        logic b;
        int n;
        r = bits;
        n = 0;
        for (int l = 0; l < LOG_WAYS; l++) begin
            b = way[LOG_WAYS-1-l];
            r[n] = ~b;
            n = 2 * n + 1 + int'(b);
        end
        return r;
    endfunction

    assign unused_in = ^{full_PC_REQ, update0_start_full_PC,
                         update1_target_full_PC, ASID_REQ, update0_ASID};

    assign req_idx  = get_idx(full_PC_REQ);
    assign req_tag  = get_tag(full_PC_REQ, ASID_REQ);
    assign u0_idx   = get_idx(update0_start_full_PC);
    assign u0_slot  = get_slot(update0_start_full_PC);
    assign u0_tag   = get_tag(update0_start_full_PC, update0_ASID);

    assign ready_REQ  = (state_q == IDLE);
    assign req_fire   = valid_REQ & ready_REQ;
    assign wr_en      = u1_valid_q & ~update1_invalidate & (state_q == IDLE) & ~RST;

    assign valid_RESP              = valid_resp_q;
    assign hit_by_instr_RESP       = hit_q;
    assign pred_info_by_instr_RESP = pi_q;
    assign target_by_instr_RESP    = tgt_q;
    assign way_by_instr_RESP       = way_q;
    assign flush_done              = flush_done_q;

    // Per-slot tag match; lowest matching way wins, misses report the PLRU victim.
    always_comb begin
        lk_hit = '0;
        lk_pi  = '0;
        lk_tgt = '0;
        lk_way = '0;
        ent    = '0;
        for (int e = 0; e < EPB; e++) begin
            lk_way[e*LOG_WAYS +: LOG_WAYS] = plru_victim(plru_q[req_idx][e*PLW +: PLW]);
            for (int w = BTB_WAYS - 1; w >= 0; w--) begin
                ent = mem_q[req_idx][e*BTB_WAYS+w];
                if (vld_q[req_idx][e*BTB_WAYS+w] && ent[TGW +: TAGW] == req_tag) begin
                    lk_hit[e]                      = 1'b1;
                    lk_pi[e*PIW +: PIW]            = ent[TGW+TAGW +: PIW];
                    lk_tgt[e*TGW +: TGW]           = ent[TGW-1:0];
                    lk_way[e*LOG_WAYS +: LOG_WAYS] = LOG_WAYS'(w);
                end
            end
        end
    end

    // Update1 PLRU row: forward the previous write to the same set over the stale read.
    always_comb begin
        u1_base    = (fwd_q && fwd_idx_q == u1_idx_q) ? fwd_row_q : u1_row_q;
        u1_new_row = u1_base;
        u1_new_row[int'(u1_slot_q)*PLW +: PLW] =
            plru_touch(u1_base[int'(u1_slot_q)*PLW +: PLW], update1_way);
    end

    // Lookup response registers, zeroed whenever no response is being returned.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_resp_q <= 1'b0;
            hit_q        <= '0;
            pi_q         <= '0;
            tgt_q        <= '0;
            way_q        <= '0;
        end else begin
            valid_resp_q <= req_fire;
            hit_q        <= req_fire ? lk_hit : '0;
            pi_q         <= req_fire ? lk_pi  : '0;
            tgt_q        <= req_fire ? lk_tgt : '0;
            way_q        <= req_fire ? lk_way : '0;
        end
    end

    // Update0 capture plus the forwarding record of the last update1 write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            u1_valid_q <= 1'b0;
            u1_idx_q   <= '0;
            u1_slot_q  <= '0;
            u1_tag_q   <= '0;
            u1_row_q   <= '0;
            fwd_q      <= 1'b0;
            fwd_idx_q  <= '0;
            fwd_row_q  <= '0;
        end else begin
            u1_valid_q <= update0_valid;
            u1_idx_q   <= u0_idx;
            u1_slot_q  <= u0_slot;
            u1_tag_q   <= u0_tag;
            u1_row_q   <= plru_q[u0_idx];
            fwd_q      <= wr_en;
            fwd_idx_q  <= u1_idx_q;
            fwd_row_q  <= u1_new_row;
        end
    end

    // Valid and PLRU state: reset, per-set flush clear, or the update1 write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < BTB_SETS; s++) begin
                vld_q[s]  <= '0;
                plru_q[s] <= '0;
            end
        end else if (state_q == FLUSH) begin
            vld_q[flush_cnt_q]  <= '0;
            plru_q[flush_cnt_q] <= '0;
        end else if (u1_valid_q) begin
            vld_q[u1_idx_q][{u1_slot_q, update1_way}] <= ~update1_invalidate;
            if (!update1_invalidate) begin
                plru_q[u1_idx_q] <= u1_new_row;
            end
        end
    end

    // Entry payload; meaningless unless the matching valid bit is set.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[u1_idx_q][{u1_slot_q, update1_way}] <=
                {update1_pred_info, u1_tag_q, update1_target_full_PC[TGW:1]};
        end
    end

    // Flush sequencer: walks every set once, then pulses flush_done.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            flush_cnt_q  <= '0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (flush_req) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= '0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == LOG_SETS'(BTB_SETS - 1)) begin
                        state_q      <= IDLE;
                        flush_cnt_q  <= '0;
                        flush_done_q <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btb_nway.sv
// tb_btb_nway: directed and randomized checks of btb_nway against
// an array-based reference model of the buffer.
module tb_btb_nway;

    localparam int SETS = 512;
    localparam int WAYS = 4;
    localparam int EPB  = 8;
    localparam int PIW  = 8;
    localparam int TAGW = 6;
    localparam int TGW  = 10;
    localparam int AW   = 9;
    localparam int LS   = 9;
    localparam int LW   = 2;
    localparam int LE   = 3;
    localparam int RW   = EPB * (1 + PIW + TGW + LW);

    logic CLK = 1'b0;
    logic RST;
    logic valid_REQ;
    logic [31:0] full_PC_REQ;
    logic [AW-1:0] ASID_REQ;
    logic ready_REQ;
    logic valid_RESP;
    logic [EPB-1:0] hit_by_instr_RESP;
    logic [EPB*PIW-1:0] pred_info_by_instr_RESP;
    logic [EPB*TGW-1:0] target_by_instr_RESP;
    logic [EPB*LW-1:0] way_by_instr_RESP;
    logic update0_valid;
    logic [31:0] update0_start_full_PC;
    logic [AW-1:0] update0_ASID;
    logic [PIW-1:0] update1_pred_info;
    logic [LW-1:0] update1_way;
    logic [31:0] update1_target_full_PC;
    logic update1_invalidate;
    logic flush_req;
    logic flush_done;

    always #5 CLK = ~CLK;

    btb_nway dut (
        .CLK(CLK),
        .RST(RST),
        .valid_REQ(valid_REQ),
        .full_PC_REQ(full_PC_REQ),
        .ASID_REQ(ASID_REQ),
        .ready_REQ(ready_REQ),
        .valid_RESP(valid_RESP),
        .hit_by_instr_RESP(hit_by_instr_RESP),
        .pred_info_by_instr_RESP(pred_info_by_instr_RESP),
        .target_by_instr_RESP(target_by_instr_RESP),
        .way_by_instr_RESP(way_by_instr_RESP),
        .update0_valid(update0_valid),
        .update0_start_full_PC(update0_start_full_PC),
        .update0_ASID(update0_ASID),
        .update1_pred_info(update1_pred_info),
        .update1_way(update1_way),
        .update1_target_full_PC(update1_target_full_PC),
        .update1_invalidate(update1_invalidate),
        .flush_req(flush_req),
        .flush_done(flush_done)
    );

    // reference model: plain arrays indexed [set][slot][way]
    bit m_v   [SETS][EPB][WAYS];
    int m_pi  [SETS][EPB][WAYS];
    int m_tag [SETS][EPB][WAYS];
    int m_tgt [SETS][EPB][WAYS];
    bit m_pl  [SETS][EPB][WAYS-1];

    int n_tests = 0;
    int n_fail  = 0;

    logic [EPB-1:0]     e_hit;
    logic [EPB*PIW-1:0] e_pi;
    logic [EPB*TGW-1:0] e_tgt;
    logic [EPB*LW-1:0]  e_way;
    logic [RW-1:0]      resp;
    logic [RW-1:0]      exp_resp;

    assign resp = {hit_by_instr_RESP, pred_info_by_instr_RESP,
                   target_by_instr_RESP, way_by_instr_RESP};
    assign exp_resp = {e_hit, e_pi, e_tgt, e_way};

    function automatic int f_set(input logic [31:0] pc);
        return int'((pc >> (LE + 1)) % SETS);
    endfunction

    function automatic int f_slot(input logic [31:0] pc);
        return int'((pc >> 1) % EPB);
    endfunction

    function automatic int f_tag(input logic [31:0] pc, input logic [AW-1:0] asid);
        return int'((pc >> (LS + LE + 1)) % (1 << TAGW)) ^ (int'(asid) % (1 << TAGW));
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < SETS; s++)
            for (int e = 0; e < EPB; e++) begin
                for (int w = 0; w < WAYS; w++) m_v[s][e][w] = 1'b0;
                for (int k = 0; k < WAYS - 1; k++) m_pl[s][e][k] = 1'b0;
            end
    endfunction

    function automatic int m_victim(input int s, input int e);
        int n, w, b;
        n = 0;
        w = 0;
        for (int l = 0; l < LW; l++) begin
            b = int'(m_pl[s][e][n]);
            w = w * 2 + b;
            n = 2 * n + 1 + b;
        end
        return w;
    endfunction

    function automatic void m_write(input logic [31:0] pc, input logic [AW-1:0] asid,
                                    input int way, input logic [PIW-1:0] pi,
                                    input logic [31:0] tgt, input bit inv);
        int s, e, n, b;
        s = f_set(pc);
        e = f_slot(pc);
        if (inv) begin
            m_v[s][e][way] = 1'b0;
        end else begin
            m_v[s][e][way]   = 1'b1;
            m_pi[s][e][way]  = int'(pi);
            m_tag[s][e][way] = f_tag(pc, asid);
            m_tgt[s][e][way] = int'((tgt >> 1) % (1 << TGW));
            n = 0;
            for (int l = 0; l < LW; l++) begin
                b = (way >> (LW - 1 - l)) & 1;
                m_pl[s][e][n] = (b == 0);
                n = 2 * n + 1 + b;
            end
        end
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, input logic [AW-1:0] asid);
        int s, t;
        s = f_set(pc);
        t = f_tag(pc, asid);
        e_hit = '0;
        e_pi  = '0;
        e_tgt = '0;
        e_way = '0;
        for (int e = 0; e < EPB; e++) begin
            e_way[e*LW +: LW] = LW'(m_victim(s, e));
            for (int w = 0; w < WAYS; w++) begin
                if (m_v[s][e][w] && m_tag[s][e][w] == t) begin
                    e_hit[e]            = 1'b1;
                    e_pi[e*PIW +: PIW]  = PIW'(m_pi[s][e][w]);
                    e_tgt[e*TGW +: TGW] = TGW'(m_tgt[s][e][w]);
                    e_way[e*LW +: LW]   = LW'(w);
                    break;
                end
            end
        end
    endfunction

    task automatic do_reset();
        RST = 1'b1;
        valid_REQ = 1'b0;
        full_PC_REQ = '0;
        ASID_REQ = '0;
        update0_valid = 1'b0;
        update0_start_full_PC = '0;
        update0_ASID = '0;
        update1_pred_info = '0;
        update1_way = '0;
        update1_target_full_PC = '0;
        update1_invalidate = 1'b0;
        flush_req = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        m_reset();
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [AW-1:0] asid);
        valid_REQ = 1'b1;
        full_PC_REQ = pc;
        ASID_REQ = asid;
        m_lookup(pc, asid);
        @(posedge CLK); #1;
        valid_REQ = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic [AW-1:0] asid, input int way,
                          input logic [PIW-1:0] pi, input logic [31:0] tgt, input bit inv);
        update0_valid = 1'b1;
        update0_start_full_PC = pc;
        update0_ASID = asid;
        @(posedge CLK); #1;
        update0_valid = 1'b0;
        update1_pred_info = pi;
        update1_way = LW'(way);
        update1_target_full_PC = tgt;
        update1_invalidate = inv;
        @(posedge CLK); #1;
        m_write(pc, asid, way, pi, tgt, inv);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (ready_REQ !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %0b want 1", ready_REQ);
        end
        n_tests++;
        if (valid_RESP !== 1'b0 || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got valid=%0b done=%0b want 0 0", valid_RESP, flush_done);
        end
        n_tests++;
        if (resp !== '0) begin
            n_fail++;
            $display("FAIL reset_resp got %h want 0", resp);
        end
        lookup(32'h1000, '0);
        n_tests++;
        if (valid_RESP !== 1'b1) begin
            n_fail++;
            $display("FAIL first_lookup_valid got %0b want 1", valid_RESP);
        end
        n_tests++;
        if (hit_by_instr_RESP !== 8'h00 || way_by_instr_RESP !== 16'h0000) begin
            n_fail++;
            $display("FAIL first_lookup hit=%h way=%h want 00 0000",
                     hit_by_instr_RESP, way_by_instr_RESP);
        end
        @(posedge CLK); #1;
        n_tests++;
        if (valid_RESP !== 1'b0 || resp !== '0) begin
            n_fail++;
            $display("FAIL resp_idle got valid=%0b resp=%h want 0 0", valid_RESP, resp);
        end
    endtask

    task automatic test_write_hit();
        update(32'h1004, '0, 1, 8'hA5, 32'h2000, 1'b0);
        lookup(32'h1000, '0);
        n_tests++;
        if (resp !== exp_resp) begin
            n_fail++;
            $display("FAIL write_hit_resp got %h want %h", resp, exp_resp);
        end
        n_tests++;
        if (hit_by_instr_RESP !== 8'h04 || pred_info_by_instr_RESP[23:16] !== 8'hA5 ||
            target_by_instr_RESP[29:20] !== 10'h000 || way_by_instr_RESP[5:4] !== 2'd1) begin
            n_fail++;
            $display("FAIL write_hit_slot2 hit=%h pi=%h tgt=%h way=%0d want 04 a5 000 1",
                     hit_by_instr_RESP, pred_info_by_instr_RESP[23:16],
                     target_by_instr_RESP[29:20], way_by_instr_RESP[5:4]);
        end
    endtask

    task automatic test_asid();
        lookup(32'h1000, 9'd1);
        n_tests++;
        if (hit_by_instr_RESP !== 8'h00 || resp !== exp_resp) begin
            n_fail++;
            $display("FAIL asid1_miss got %h want %h", resp, exp_resp);
        end
        lookup(32'h1000, 9'd0);
        n_tests++;
        if (hit_by_instr_RESP !== 8'h04 || resp !== exp_resp) begin
            n_fail++;
            $display("FAIL asid0_hit got %h want %h", resp, exp_resp);
        end
    endtask

    task automatic test_plru_seq();
        int seq [4] = '{0, 2, 1, 3};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            lookup(32'h1230, 9'd7);
            n_tests++;
            if (way_by_instr_RESP[1:0] !== LW'(seq[i]) || resp !== exp_resp) begin
                n_fail++;
                $display("FAIL plru_victim_%0d got way %0d want %0d (resp %h want %h)",
                         i, way_by_instr_RESP[1:0], seq[i], resp, exp_resp);
            end
            update(32'h1230, '0, m_victim(f_set(32'h1230), 0), PIW'(8'h10 + i), 32'h400, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int wa, wb;
        wa = m_victim(f_set(32'h2340), 0);
        wb = m_victim(f_set(32'h2342), 1);
        update0_valid = 1'b1;
        update0_start_full_PC = 32'h2340;
        update0_ASID = '0;
        @(posedge CLK); #1;
        update1_pred_info = 8'h11;
        update1_way = LW'(wa);
        update1_target_full_PC = 32'h0AA;
        update1_invalidate = 1'b0;
        update0_start_full_PC = 32'h2342;
        @(posedge CLK); #1;
        update0_valid = 1'b0;
        update1_pred_info = 8'h22;
        update1_way = LW'(wb);
        update1_target_full_PC = 32'h0BB;
        @(posedge CLK); #1;
        m_write(32'h2340, '0, wa, 8'h11, 32'h0AA, 1'b0);
        m_write(32'h2342, '0, wb, 8'h22, 32'h0BB, 1'b0);
        lookup(32'h2340, 9'd5);
        n_tests++;
        if (way_by_instr_RESP[1:0] !== 2'd2 || way_by_instr_RESP[3:2] !== 2'd2) begin
            n_fail++;
            $display("FAIL b2b_victims got slot0=%0d slot1=%0d want 2 2",
                     way_by_instr_RESP[1:0], way_by_instr_RESP[3:2]);
        end
        n_tests++;
        if (resp !== exp_resp) begin
            n_fail++;
            $display("FAIL b2b_resp got %h want %h", resp, exp_resp);
        end
    endtask

    task automatic test_read_before_write();
        update0_valid = 1'b1;
        update0_start_full_PC = 32'h3450;
        update0_ASID = '0;
        @(posedge CLK); #1;
        update0_valid = 1'b0;
        update1_pred_info = 8'h5A;
        update1_way = 2'd3;
        update1_target_full_PC = 32'h3FE;
        update1_invalidate = 1'b0;
        valid_REQ = 1'b1;
        full_PC_REQ = 32'h3450;
        ASID_REQ = '0;
        m_lookup(32'h3450, '0);
        @(posedge CLK); #1;
        valid_REQ = 1'b0;
        m_write(32'h3450, '0, 3, 8'h5A, 32'h3FE, 1'b0);
        n_tests++;
        if (hit_by_instr_RESP[0] !== 1'b0 || resp !== exp_resp) begin
            n_fail++;
            $display("FAIL rbw_old got %h want %h", resp, exp_resp);
        end
        lookup(32'h3450, '0);
        n_tests++;
        if (hit_by_instr_RESP[0] !== 1'b1 || resp !== exp_resp) begin
            n_fail++;
            $display("FAIL rbw_new got %h want %h", resp, exp_resp);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 120; it++) begin
            logic [31:0] pc;
            logic [AW-1:0] asid;
            int way;
            pc = (32'($urandom_range(0, 3)) << 13) | (32'($urandom_range(0, 3)) << 4) |
                 (32'($urandom_range(0, 7)) << 1);
            asid = AW'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                way = ($urandom_range(0, 1) == 1) ? m_victim(f_set(pc), f_slot(pc))
                                                  : int'($urandom_range(0, 3));
                update(pc, asid, way, PIW'($urandom), $urandom,
                       $urandom_range(0, 7) == 0);
            end else begin
                lookup(pc, asid);
                n_tests++;
                if (valid_RESP !== 1'b1 || resp !== exp_resp) begin
                    n_fail++;
                    $display("FAIL random_%0d pc=%h asid=%0d got %h want %h",
                             it, pc, asid, resp, exp_resp);
                end
            end
        end
    endtask

    task automatic test_flush();
        int busy, early_done;
        busy = 0;
        early_done = 0;
        update(32'h5670, '0, 0, 8'h77, 32'h222, 1'b0);
        flush_req = 1'b1;
        @(posedge CLK); #1;
        flush_req = 1'b0;
        while (ready_REQ !== 1'b1 && busy < 2000) begin
            if (flush_done) early_done++;
            if (busy == 20) begin
                update0_valid = 1'b1;
                update0_start_full_PC = 32'h5670;
                update0_ASID = '0;
            end
            if (busy == 21) begin
                update0_valid = 1'b0;
                update1_pred_info = 8'h3C;
                update1_way = 2'd1;
                update1_target_full_PC = 32'h100;
                update1_invalidate = 1'b0;
            end
            if (busy == 30) begin
                valid_REQ = 1'b1;
                full_PC_REQ = 32'h1000;
                ASID_REQ = '0;
            end
            if (busy == 31) begin
                valid_REQ = 1'b0;
                n_tests++;
                if (valid_RESP !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_req_blocked got valid=%0b want 0", valid_RESP);
                end
            end
            @(posedge CLK); #1;
            busy++;
        end
        n_tests++;
        if (busy != SETS) begin
            n_fail++;
            $display("FAIL flush_busy_cycles got %0d want %0d", busy, SETS);
        end
        n_tests++;
        if (flush_done !== 1'b1 || early_done != 0) begin
            n_fail++;
            $display("FAIL flush_done_pulse got done=%0b early=%0d want 1 0",
                     flush_done, early_done);
        end
        m_reset();
        @(posedge CLK); #1;
        n_tests++;
        if (flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_done_width got %0b want 0", flush_done);
        end
        lookup(32'h1000, '0);
        n_tests++;
        if (hit_by_instr_RESP !== 8'h00 || resp !== exp_resp) begin
            n_fail++;
            $display("FAIL post_flush_1000 got %h want %h", resp, exp_resp);
        end
        lookup(32'h5670, '0);
        n_tests++;
        if (hit_by_instr_RESP !== 8'h00 || resp !== exp_resp) begin
            n_fail++;
            $display("FAIL post_flush_5670 got %h want %h", resp, exp_resp);
        end
        lookup(32'h3450, '0);
        n_tests++;
        if (hit_by_instr_RESP !== 8'h00 || resp !== exp_resp) begin
            n_fail++;
            $display("FAIL post_flush_3450 got %h want %h", resp, exp_resp);
        end
    endtask

    task automatic test_reset_in_flush();
        int pulses;
        pulses = 0;
        flush_req = 1'b1;
        @(posedge CLK); #1;
        flush_req = 1'b0;
        repeat (5) begin
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        n_tests++;
        if (ready_REQ !== 1'b1 || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort got ready=%0b done=%0b want 1 0", ready_REQ, flush_done);
        end
        RST = 1'b0;
        m_reset();
        repeat (600) begin
            if (flush_done) pulses++;
            @(posedge CLK); #1;
        end
        n_tests++;
        if (pulses != 0 || ready_REQ !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_done got pulses=%0d ready=%0b want 0 1", pulses, ready_REQ);
        end
    endtask

    initial begin
        test_reset();
        test_write_hit();
        test_asid();
        test_plru_seq();
        test_back_to_back();
        test_read_before_write();
        test_random();
        test_flush();
        test_reset_in_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
